alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// - Shares the single execute-stage ALU between two requesters: port 0 = pipeline execute, port 1 = branch/compare unit.
// - Arbitrates and captures operands; drives the ALU from registers for one full cycle; returns a registered result.
// - Sits between the execute-stage issue logic and the combinational ALU (ALU is instantiated outside this block).
// PARAMETERS
// DATA_W      32  operand/result width
// OP_W        5   ALU opcode width
// STARVE_MAX  4   fixed-priority mode only: max consecutive port-0 grants while port 1 waits (range 1..15)
// PORTS
// clk           in   1       clock, rising edge
// rst_n         in   1       asynchronous active-low reset
// req0_valid    in   1       port 0 request valid
// req0_ready    out  1       port 0 request accepted this cycle
// req0_aluop    in   OP_W    port 0 ALU opcode
// req0_sign     in   1       port 0 signed select (sub/slt)
// req0_a        in   DATA_W  port 0 operand 1
// req0_b        in   DATA_W  port 0 operand 2 / shift amount [4:0]
// req1_*        -    -       same six signals for port 1
// resp_valid    out  1       result valid; held until resp_ready
// resp_ready    in   1       consumer accepts result
// resp_id       out  1       port that issued the result
// resp_result   out  DATA_W  ALU result
// resp_zero     out  1       result == 0
// resp_neg      out  1       result[DATA_W-1]
// resp_err      out  1       opcode unsupported; resp_result = 0
// alu_op        out  OP_W    to ALU opcode
// alu_sign      out  1       to ALU sign
// alu_a/alu_b   out  DATA_W  to ALU operands
// alu_result    in   DATA_W  from ALU
// alu_zero      in   1       from ALU
// alu_neg       in   1       from ALU
// busy          out  1       state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (resp_*, alu_*, ready, busy); starvation counter 0; RR pointer = port 0.
// - States: IDLE -> EXEC -> RESP -> (IDLE | EXEC).
// - IDLE: if any reqN_valid, winner gets reqN_ready=1 (combinational, same cycle); op/sign/a/b/id latched; -> EXEC.
// - EXEC: alu_* driven from latched regs, stable the whole cycle; at clock edge alu_result/zero/neg captured into resp_*; -> RESP.
// - RESP: resp_valid=1; resp_* stable until resp_ready. resp_ready=1 with a valid request: accept new winner the same cycle -> EXEC; else -> IDLE.
// - Latency: acceptance edge +2 cycles to resp_valid; sustained throughput 1 op / 2 cycles.
// - alu_* hold last issued values outside EXEC (no toggling).
// - Supported opcodes 5'h00..5'h09 (add, sub, sll, xor, srl, sra, or, and, slt, pass-op2). 5'h0A..5'h1F: no ALU issue (alu_op forced 0); EXEC still spent; resp_err=1, resp_result=0, resp_zero=1, resp_neg=0.
// - resp_err clears with the next response.
// - Simultaneous valid: arbitration per CONFIGURATION; loser's ready=0; loser must hold its request stable.
// - Request dropped (valid falls) before ready: no effect, nothing captured.
// - rst_n low mid-op: in-flight op discarded, no response issued; resumes at IDLE.
// CONFIGURATION
// - ALU_ARB_RR_EN defined: round-robin; pointer flips to the other port after every grant; STARVE_MAX ignored.
// - ALU_ARB_RR_EN undefined: port 0 fixed priority. Counter increments on each port-0 grant while req1_valid=1; resets on any port-1 grant.
// - ALU_ARB_RR_EN undefined: counter==STARVE_MAX forces the next grant to port 1.
// TESTING
// - Reset: rst_n=0 -> all outputs 0, busy=0. Then req0 add a=5 b=7 -> ready same cycle; resp_valid 2 cycles later; result=12, zero=0, id=0.
// - Port 1 sub sign=1 a=3 b=8 -> result=0xFFFFFFFB, neg=1; slt sign=1 a=-1 b=1 -> result=1.
// - Both valid every cycle, fixed priority, STARVE_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
// - Same with ALU_ARB_RR_EN -> alternating 0,1,0,1.
// - Opcode 5'h0C -> resp_err=1, result=0, zero=1; next valid op -> resp_err=0.
// - Backpressure: resp_ready=0 for 5 cycles -> resp_* stable, req ready=0. resp_ready=1 with req pending -> accept same cycle, next resp 2 cycles later.
// - rst_n pulsed low during EXEC -> no resp_valid; next request completes normally.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// ============================================================================
// alu_share_arbiter_if
// ----------------------------------------------------------------------------
// Purpose : Bundles the two request ports and the response port of the shared
//           execute-stage ALU arbiter.
// Modports:
//   master - issue side (execute pipeline, branch/compare unit, result consumer)
//   slave  - the arbiter itself
// Signals :
//   reqN_valid/ready      request handshake for port N (0 = execute, 1 = branch)
//   reqN_aluop/sign/a/b   opcode, signed select and operands for port N
//   resp_valid/ready      response handshake
//   resp_id               port that issued the result
//   resp_result/zero/neg  ALU result and flags
//   resp_err              opcode was unsupported
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_aluop;
    logic              req0_sign;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_aluop;
    logic              req1_sign;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_zero;
    logic              resp_neg;
    logic              resp_err;

    modport master (
        output req0_valid, req0_aluop, req0_sign, req0_a, req0_b,
        output req1_valid, req1_aluop, req1_sign, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_neg, resp_err
    );

    modport slave (
        input  req0_valid, req0_aluop, req0_sign, req0_a, req0_b,
        input  req1_valid, req1_aluop, req1_sign, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, resp_zero, resp_neg, resp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter
// ----------------------------------------------------------------------------
// Purpose : Shares one combinational execute-stage ALU between the execute
//           pipeline (port 0) and the branch/compare unit (port 1). Arbitrates,
//           captures operands, drives the ALU from registers for one cycle and
//           returns a registered result held until the consumer takes it.
// Ports   :
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   bus (slave)      request ports 0/1 and response port
//   o_alu_op/sign/a/b  registered drive to the external ALU
//   i_alu_result/zero/neg  combinational result from the external ALU
//   o_busy           high whenever the arbiter is not idle
// Config  : define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0
//           has fixed priority with a starvation limit of STARVE_MAX grants.
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [OP_W-1:0]      o_alu_op,
    output logic                 o_alu_sign,
    output logic [DATA_W-1:0]    o_alu_a,
    output logic [DATA_W-1:0]    o_alu_b,
    input  logic [DATA_W-1:0]    i_alu_result,
    input  logic                 i_alu_zero,
    input  logic                 i_alu_neg,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [OP_W-1:0]   r_aluOp;
    logic              r_aluSign;
    logic [DATA_W-1:0] r_aluA;
    logic [DATA_W-1:0] r_aluB;
    logic              r_opId;
    logic              r_opErr;
    logic              r_busy;
    logic              r_respValid;
    logic              r_respId;
    logic [DATA_W-1:0] r_respResult;
    logic              r_respZero;
    logic              r_respNeg;
    logic              r_respErr;

    logic              w_canAccept;
    logic              w_accept;
    logic              w_grantId;
    logic [OP_W-1:0]   w_selOp;
    logic              w_selSign;
    logic [DATA_W-1:0] w_selA;
    logic [DATA_W-1:0] w_selB;
    logic              w_opOk;

`ifdef ALU_ARB_RR_EN
    logic              r_rrPtr;

    // Contention goes to the pointed-at port; a lone requester always wins.
    assign w_grantId = bus.req1_valid && (!bus.req0_valid || r_rrPtr);
`else
    logic [3:0]        r_starveCnt;
    logic              w_forcePort1;

    // Port 0 wins contention until it has been granted STARVE_MAX times in a
    // row while port 1 waited.
    assign w_forcePort1 = (r_starveCnt == 4'(STARVE_MAX));
    assign w_grantId    = bus.req1_valid && (!bus.req0_valid || w_forcePort1);
`endif

    // A new request can be taken from IDLE, or from RESP in the same cycle the
    // current result is consumed. Reset gates ready so nothing is accepted.
    assign w_canAccept = rst_n && ((r_state == IDLE) ||
                                   (r_state == RESP && bus.resp_ready));
    assign w_accept    = w_canAccept && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = w_accept && !w_grantId;
    assign bus.req1_ready = w_accept &&  w_grantId;

    assign w_selOp   = w_grantId ? bus.req1_aluop : bus.req0_aluop;
    assign w_selSign = w_grantId ? bus.req1_sign  : bus.req0_sign;
    assign w_selA    = w_grantId ? bus.req1_a     : bus.req0_a;
    assign w_selB    = w_grantId ? bus.req1_b     : bus.req0_b;
    assign w_opOk    = (w_selOp <= OP_W'(9));

    assign o_alu_op        = r_aluOp;
    assign o_alu_sign      = r_aluSign;
    assign o_alu_a         = r_aluA;
    assign o_alu_b         = r_aluB;
    assign o_busy          = r_busy;
    assign bus.resp_valid  = r_respValid;
    assign bus.resp_id     = r_respId;
    assign bus.resp_result = r_respResult;
    assign bus.resp_zero   = r_respZero;
    assign bus.resp_neg    = r_respNeg;
    assign bus.resp_err    = r_respErr;

    // Control FSM. Operands are captured on acceptance and go straight to the
    // ALU drive registers, so the ALU sees them for the whole EXEC cycle and
    // they hold afterwards. Unsupported opcodes leave the operands untouched
    // and park the opcode at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_aluOp      <= '0;
            r_aluSign    <= 1'b0;
            r_aluA       <= '0;
            r_aluB       <= '0;
            r_opId       <= 1'b0;
            r_opErr      <= 1'b0;
            r_busy       <= 1'b0;
            r_respValid  <= 1'b0;
            r_respId     <= 1'b0;
            r_respResult <= '0;
            r_respZero   <= 1'b0;
            r_respNeg    <= 1'b0;
            r_respErr    <= 1'b0;
`ifdef ALU_ARB_RR_EN
            r_rrPtr      <= 1'b0;
`else
            r_starveCnt  <= 4'd0;
`endif
        end else begin
            if (w_accept) begin
                r_opId  <= w_grantId;
                r_opErr <= !w_opOk;
                if (w_opOk) begin
                    r_aluOp   <= w_selOp;
                    r_aluSign <= w_selSign;
                    r_aluA    <= w_selA;
                    r_aluB    <= w_selB;
                end else begin
                    r_aluOp   <= '0;
                end
`ifdef ALU_ARB_RR_EN
                r_rrPtr <= !w_grantId;
`else
                if (w_grantId) begin
                    r_starveCnt <= 4'd0;
                end else if (bus.req1_valid && r_starveCnt != 4'hF) begin
                    r_starveCnt <= r_starveCnt + 4'd1;
                end
`endif
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= EXEC;
                        r_busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    r_respValid  <= 1'b1;
                    r_respId     <= r_opId;
                    r_respErr    <= r_opErr;
                    r_respResult <= r_opErr ? '0   : i_alu_result;
                    r_respZero   <= r_opErr ? 1'b1 : i_alu_zero;
                    r_respNeg    <= r_opErr ? 1'b0 : i_alu_neg;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_respValid <= 1'b0;
                        if (w_accept) begin
                            r_state <= EXEC;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// tb_alu_share_arbiter
// ----------------------------------------------------------------------------
// Directed testbench for alu_share_arbiter. Models the external ALU and
// checks reset, single ops on both ports, unsupported opcodes, backpressure,
// arbitration order and reset in the middle of an operation.
// ============================================================================
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    logic [OP_W-1:0]   aluOp;
    logic              aluSign;
    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluResult;
    logic              aluZero;
    logic              aluNeg;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_alu_op     (aluOp),
        .o_alu_sign   (aluSign),
        .o_alu_a      (aluA),
        .o_alu_b      (aluB),
        .i_alu_result (aluResult),
        .i_alu_zero   (aluZero),
        .i_alu_neg    (aluNeg),
        .o_busy       (busy)
    );

    // External combinational ALU.
    always_comb begin
        aluResult = '0;
        case (aluOp)
            5'h00: aluResult = aluA + aluB;
            5'h01: aluResult = aluA - aluB;
            5'h02: aluResult = aluA << aluB[4:0];
            5'h03: aluResult = aluA ^ aluB;
            5'h04: aluResult = aluA >> aluB[4:0];
            5'h05: aluResult = $signed(aluA) >>> aluB[4:0];
            5'h06: aluResult = aluA | aluB;
            5'h07: aluResult = aluA & aluB;
            5'h08: aluResult = aluSign ? {31'd0, $signed(aluA) < $signed(aluB)}
                                       : {31'd0, aluA < aluB};
            5'h09: aluResult = aluB;
            default: aluResult = '0;
        endcase
        aluZero = (aluResult == '0);
        aluNeg  = aluResult[DATA_W-1];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearInputs();
        bus.req0_valid = 1'b0; bus.req0_aluop = '0; bus.req0_sign = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_aluop = '0; bus.req1_sign = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0;
        bus.resp_ready = 1'b0;
    endtask

    // Presents one request, waits (bounded) for acceptance and the response,
    // returns the response fields and the latency in cycles, then consumes it.
    task automatic issue(input int port, input logic [4:0] op, input logic sign,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res,
                         output logic zero, output logic neg,
                         output logic err, output logic id);
        int waitCnt;
        @(negedge clk);
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_aluop = op; bus.req0_sign = sign;
            bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_aluop = op; bus.req1_sign = sign;
            bus.req1_a = a; bus.req1_b = b;
        end
        #1;
        waitCnt = 0;
        while (!(bus.req0_ready || bus.req1_ready) && waitCnt < 10) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = i;
                break;
            end
        end
        res  = bus.resp_result;
        zero = bus.resp_zero;
        neg  = bus.resp_neg;
        err  = bus.resp_err;
        id   = bus.resp_id;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_zero, bus.resp_neg, bus.resp_err} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_resp_flags: got %b expected 00000",
                     {bus.resp_valid, bus.resp_id, bus.resp_zero, bus.resp_neg, bus.resp_err});
        end
        checks++;
        if ({busy, bus.req0_ready, bus.req1_ready, aluSign} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000",
                     {busy, bus.req0_ready, bus.req1_ready, aluSign});
        end
        checks++;
        if (bus.resp_result !== 32'd0 || aluOp !== 5'd0 || aluA !== 32'd0 || aluB !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: result=%h op=%h a=%h b=%h expected all 0",
                     bus.resp_result, aluOp, aluA, aluB);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_aluop = 5'h00; bus.req0_sign = 1'b0;
        bus.req0_a = 32'd5; bus.req0_b = 32'd7;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_ready: got r0=%b r1=%b expected r0=1 r1=0",
                     bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || busy !== 1'b1 || aluA !== 32'd5 || aluB !== 32'd7) begin
            failures++;
            $display("[TB] FAIL add_exec: valid=%b busy=%b a=%0d b=%0d expected 0 1 5 7",
                     bus.resp_valid, busy, aluA, aluB);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd12 ||
            bus.resp_zero !== 1'b0 || bus.resp_id !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_resp: valid=%b result=%0d zero=%b id=%b expected 1 12 0 0",
                     bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_id);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add_idle: valid=%b busy=%b expected 0 0", bus.resp_valid, busy);
        end
    endtask

    task automatic test_port1();
        int lat;
        logic [31:0] res;
        logic zero, neg, err, id;
        issue(1, 5'h01, 1'b1, 32'd3, 32'd8, lat, res, zero, neg, err, id);
        checks++;
        if (lat !== 2 || res !== 32'hFFFF_FFFB || neg !== 1'b1 || zero !== 1'b0 || id !== 1'b1) begin
            failures++;
            $display("[TB] FAIL p1_sub: lat=%0d res=%h neg=%b zero=%b id=%b expected 2 fffffffb 1 0 1",
                     lat, res, neg, zero, id);
        end
        issue(1, 5'h08, 1'b1, 32'hFFFF_FFFF, 32'd1, lat, res, zero, neg, err, id);
        checks++;
        if (lat !== 2 || res !== 32'd1 || id !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL p1_slt: lat=%0d res=%h id=%b err=%b expected 2 00000001 1 0",
                     lat, res, id, err);
        end
        issue(0, 5'h05, 1'b0, 32'h8000_0000, 32'd4, lat, res, zero, neg, err, id);
        checks++;
        if (res !== 32'hF800_0000 || neg !== 1'b1 || id !== 1'b0) begin
            failures++;
            $display("[TB] FAIL p0_sra: res=%h neg=%b id=%b expected f8000000 1 0", res, neg, id);
        end
    endtask

    task automatic test_err();
        int lat;
        logic [31:0] res;
        logic zero, neg, err, id;
        issue(0, 5'h0C, 1'b0, 32'd9, 32'd1, lat, res, zero, neg, err, id);
        checks++;
        if (lat !== 2 || err !== 1'b1 || res !== 32'd0 || zero !== 1'b1 || neg !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_op: lat=%0d err=%b res=%h zero=%b neg=%b expected 2 1 0 1 0",
                     lat, err, res, zero, neg);
        end
        checks++;
        if (aluOp !== 5'h00) begin
            failures++;
            $display("[TB] FAIL err_aluop: got %h expected 00", aluOp);
        end
        issue(0, 5'h03, 1'b0, 32'h0000_00F0, 32'h0000_00FF, lat, res, zero, neg, err, id);
        checks++;
        if (err !== 1'b0 || res !== 32'h0000_000F || zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_clear: err=%b res=%h zero=%b expected 0 0000000f 0",
                     err, res, zero);
        end
    endtask

    task automatic test_backpressure();
        logic stable;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_aluop = 5'h00; bus.req0_sign = 1'b0;
        bus.req0_a = 32'd1; bus.req0_b = 32'd2;
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_aluop = 5'h01; bus.req1_sign = 1'b0;
        bus.req1_a = 32'd10; bus.req1_b = 32'd4;
        @(negedge clk);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd3 || bus.resp_id !== 1'b0 ||
                bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_hold: got valid=%b result=%0d id=%b r1=%b expected 1 3 0 0",
                     bus.resp_valid, bus.resp_result, bus.resp_id, bus.req1_ready);
        end
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_accept: got r1=%b expected 1", bus.req1_ready);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_exec: got valid=%b expected 0", bus.resp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd6 || bus.resp_id !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_next: valid=%b result=%0d id=%b expected 1 6 1",
                     bus.resp_valid, bus.resp_result, bus.resp_id);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_arbitration();
        logic expGrant [10];
        logic gotGrant [10];
        int   n;
`ifdef ALU_ARB_RR_EN
        expGrant = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        expGrant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_aluop = 5'h00; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        bus.req1_valid = 1'b1; bus.req1_aluop = 5'h06; bus.req1_a = 32'd2; bus.req1_b = 32'd4;
        bus.resp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                gotGrant[n] = bus.req1_ready;
                n++;
            end
            if (n < 10) @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        checks++;
        if (n !== 10) begin
            failures++;
            $display("[TB] FAIL arb_count: got %0d grants expected 10", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (gotGrant[i] !== expGrant[i]) begin
                failures++;
                $display("[TB] FAIL arb_grant%0d: got port %0d expected port %0d",
                         i, gotGrant[i], expGrant[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        logic zero, neg, err, id;
        logic sawValid;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_aluop = 5'h00; bus.req0_a = 32'd9; bus.req0_b = 32'd9;
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_clear: busy=%b valid=%b expected 0 0", busy, bus.resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_noresp: got resp_valid seen=%b expected 0", sawValid);
        end
        issue(0, 5'h07, 1'b0, 32'h0000_00FF, 32'h0000_000F, lat, res, zero, neg, err, id);
        checks++;
        if (lat !== 2 || res !== 32'h0000_000F || id !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_after: lat=%0d res=%h id=%b err=%b expected 2 0000000f 0 0",
                     lat, res, id, err);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_port1();
        test_err();
        test_backpressure();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
